vip_control_packet_decoder: RTL and testbench



---
 rtl/vip_control_packet_decoder.sv | 124 ++++++++++++
 tb/tb_vip_control_packet_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vip_control_packet_decoder.sv
// Avalon-ST VIP stream parser: decodes control packets into width/height/interlace
// fields, forwards video packets without their header beat, and drops everything else.
module vip_control_packet_decoder #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic                                        dout_sop,
    output logic                                        dout_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic [15:0]                                 width,
    output logic [15:0]                                 height,
    output logic [3:0]                                  interlaced,
    output logic                                        ctrl_valid,
    output logic                                        stream_error
);

    typedef enum logic [1:0] {WAIT_SOP, CTRL, VIDEO, DISCARD} state_t;

    state_t            state, state_n;
    logic              first;
    logic [3:0]        sym, sym_n;
    logic [4:0]        sym_sum, idx;
    logic [8:0][3:0]   shadow, shadow_n;
    logic              ready_raw, accept, hdr;
    logic              sop_err, short_err, ctrl_done;

    assign sym_sum   = {1'b0, sym} + 5'(SYMBOLS_PER_BEAT);
    assign sym_n     = (sym_sum > 5'd9) ? 4'd9 : sym_sum[3:0];
    assign ready_raw = (state == VIDEO) ? dout_ready : 1'b1;
    // Gating with rst_n keeps the sink closed for the whole reset interval.
    assign din_ready = rst_n & ready_raw;
    assign accept    = din_valid & din_ready;
    assign dout_data = din_data;

    always_comb begin
        state_n    = state;
        dout_valid = 1'b0;
        dout_sop   = 1'b0;
        dout_eop   = 1'b0;
        hdr        = 1'b0;
        sop_err    = 1'b0;
        short_err  = 1'b0;
        ctrl_done  = 1'b0;
        case (state)
            WAIT_SOP: hdr = accept & din_sop;
            default: begin
                if (state == VIDEO) begin
                    dout_valid = din_valid & ~din_sop;
                    dout_sop   = first;
                    dout_eop   = din_eop;
                end
                if (accept) begin
                    if (din_sop) begin
                        sop_err = 1'b1;
                        hdr     = 1'b1;
                    end else if (din_eop) begin
                        state_n = WAIT_SOP;
                        if (state == CTRL) begin
                            if (sym_sum >= 5'd9) ctrl_done = 1'b1;
                            else                 short_err = 1'b1;
                        end
                    end
                end
            end
        endcase
        // A stray sop is reparsed as a fresh header in the same cycle.
        if (hdr) begin
            if (din_eop)                   state_n = WAIT_SOP;
            else if (din_data[3:0] == 4'hF) state_n = CTRL;
            else if (din_data[3:0] == 4'h0) state_n = VIDEO;
            else                           state_n = DISCARD;
        end
    end

    always_comb begin
        shadow_n = shadow;
        idx      = '0;
        if (state == CTRL && accept && !din_sop) begin
            for (int unsigned j = 0; j < SYMBOLS_PER_BEAT; j++) begin
                idx = {1'b0, sym} + 5'(j);
                if (idx < 5'd9) shadow_n[idx[3:0]] = din_data[j*BITS_PER_SYMBOL +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_SOP;
            first        <= 1'b0;
            sym          <= '0;
            shadow       <= '0;
            width        <= '0;
            height       <= '0;
            interlaced   <= '0;
            ctrl_valid   <= 1'b0;
            stream_error <= 1'b0;
        end else begin
            state        <= state_n;
            shadow       <= shadow_n;
            ctrl_valid   <= ctrl_done;
            stream_error <= sop_err | short_err;
            if (hdr)                            first <= (state_n == VIDEO);
            else if (state == VIDEO && accept)  first <= 1'b0;
            if (hdr)                            sym <= '0;
            else if (state == CTRL && accept)   sym <= sym_n;
            // shadow_n already holds the nibbles of the closing eop beat.
            if (ctrl_done) begin
                width      <= {shadow_n[0], shadow_n[1], shadow_n[2], shadow_n[3]};
                height     <= {shadow_n[4], shadow_n[5], shadow_n[6], shadow_n[7]};
                interlaced <= shadow_n[8];
            end
        end
    end

endmodule

// File: tb/tb_vip_control_packet_decoder.sv
// Directed bench for vip_control_packet_decoder (8-bit symbols, 3 per beat).
module tb_vip_control_packet_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_ready, din_valid, din_sop, din_eop;
    logic [23:0] din_data;
    logic        dout_ready, dout_valid, dout_sop, dout_eop;
    logic [23:0] dout_data;
    logic [15:0] width, height;
    logic [3:0]  interlaced;
    logic        ctrl_valid, stream_error;

    int tests = 0;
    int fails = 0;

    vip_control_packet_decoder #(
        .BITS_PER_SYMBOL(8),
        .SYMBOLS_PER_BEAT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop),
        .din_eop(din_eop), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .dout_data(dout_data),
        .width(width), .height(height), .interlaced(interlaced),
        .ctrl_valid(ctrl_valid), .stream_error(stream_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [23:0] d);
        din_valid = v;
        din_sop   = s;
        din_eop   = e;
        din_data  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        dout_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        #3;
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_width", 32'(width), 32'd0);
        check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("rst_stream_error", 32'(stream_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_din_ready", 32'(din_ready), 32'd1);
        step();

        // Control decode: 1920 x 1080, progressive
        drive(1'b1, 1'b1, 1'b0, 24'h00000F); step();
        drive(1'b1, 1'b0, 1'b0, 24'h080700); step();
        drive(1'b1, 1'b0, 1'b0, 24'h040000); step();
        check("ctrl_no_early_valid", 32'(ctrl_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 24'h000803); step();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("ctrl_valid_pulse", 32'(ctrl_valid), 32'd1);
        check("ctrl_width", 32'(width), 32'd1920);
        check("ctrl_height", 32'(height), 32'd1080);
        check("ctrl_interlaced", 32'(interlaced), 32'd0);
        check("ctrl_no_error", 32'(stream_error), 32'd0);
        step();
        check("ctrl_valid_one_cycle", 32'(ctrl_valid), 32'd0);

        // Video forward with backpressure on D1
        drive(1'b1, 1'b1, 1'b0, 24'h000000);
        #1;
        check("vid_hdr_not_fwd", 32'(dout_valid), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 24'hA1A2A3);
        #1;
        check("vid_d0_valid", 32'(dout_valid), 32'd1);
        check("vid_d0_sop", 32'(dout_sop), 32'd1);
        check("vid_d0_data", 32'(dout_data), 32'hA1A2A3);
        check("vid_d0_eop", 32'(dout_eop), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 24'hB1B2B3);
        dout_ready = 1'b0;
        #1;
        check("vid_stall1_ready", 32'(din_ready), 32'd0);
        check("vid_d1_sop", 32'(dout_sop), 32'd0);
        check("vid_d1_data", 32'(dout_data), 32'hB1B2B3);
        step();
        check("vid_stall2_ready", 32'(din_ready), 32'd0);
        check("vid_stall2_valid", 32'(dout_valid), 32'd1);
        step();
        dout_ready = 1'b1;
        #1;
        check("vid_d1_ready", 32'(din_ready), 32'd1);
        check("vid_d1_sop_held", 32'(dout_sop), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 24'hC1C2C3);
        #1;
        check("vid_d2_data", 32'(dout_data), 32'hC1C2C3);
        check("vid_d2_eop", 32'(dout_eop), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b1, 24'hD1D2D3);
        #1;
        check("vid_d3_eop", 32'(dout_eop), 32'd1);
        check("vid_d3_valid", 32'(dout_valid), 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        #1;
        check("vid_done_valid", 32'(dout_valid), 32'd0);
        check("vid_no_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("vid_back_ready", 32'(din_ready), 32'd1);
        step();

        // Short control: 6 symbols only
        drive(1'b1, 1'b1, 1'b0, 24'h00000F); step();
        drive(1'b1, 1'b0, 1'b0, 24'h111111); step();
        drive(1'b1, 1'b0, 1'b1, 24'h222222); step();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("short_error", 32'(stream_error), 32'd1);
        check("short_no_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("short_width_held", 32'(width), 32'd1920);
        check("short_height_held", 32'(height), 32'd1080);
        step();
        check("short_error_one_cycle", 32'(stream_error), 32'd0);

        // Unknown type 0x3, five beats
        drive(1'b1, 1'b1, 1'b0, 24'h000003);
        #1;
        check("unk_hdr_ready", 32'(din_ready), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, (i == 3), 24'h000F00 + 24'(i));
            #1;
            check("unk_ready", 32'(din_ready), 32'd1);
            check("unk_no_dout", 32'(dout_valid), 32'd0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("unk_no_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("unk_width_held", 32'(width), 32'd1920);
        step();

        // Sop mid-video, then a 1280 x 720 interlaced control packet
        drive(1'b1, 1'b1, 1'b0, 24'h000000); step();
        drive(1'b1, 1'b0, 1'b0, 24'h123456);
        #1;
        check("mid_v0_sop", 32'(dout_sop), 32'd1);
        check("mid_v0_valid", 32'(dout_valid), 32'd1);
        step();
        drive(1'b1, 1'b0, 1'b0, 24'h654321);
        #1;
        check("mid_v1_valid", 32'(dout_valid), 32'd1);
        check("mid_v1_eop", 32'(dout_eop), 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 24'h00000F);
        #1;
        check("mid_sop_not_fwd", 32'(dout_valid), 32'd0);
        step();
        check("mid_error", 32'(stream_error), 32'd1);
        check("mid_no_ctrl_valid", 32'(ctrl_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 24'h000500); step();
        check("mid_error_one_cycle", 32'(stream_error), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 24'h020000); step();
        drive(1'b1, 1'b0, 1'b1, 24'h01000D); step();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("mid_ctrl_valid", 32'(ctrl_valid), 32'd1);
        check("mid_width", 32'(width), 32'h0500);
        check("mid_height", 32'(height), 32'h02D0);
        check("mid_interlaced", 32'(interlaced), 32'd1);
        step();

        // Reset during 2nd payload beat of a control packet
        drive(1'b1, 1'b1, 1'b0, 24'h00000F); step();
        drive(1'b1, 1'b0, 1'b0, 24'h080700); step();
        drive(1'b1, 1'b0, 1'b0, 24'h040000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_width", 32'(width), 32'd0);
        check("mrst_height", 32'(height), 32'd0);
        check("mrst_interlaced", 32'(interlaced), 32'd0);
        check("mrst_din_ready", 32'(din_ready), 32'd0);
        check("mrst_dout_valid", 32'(dout_valid), 32'd0);
        check("mrst_dout_sop", 32'(dout_sop), 32'd0);
        check("mrst_dout_eop", 32'(dout_eop), 32'd0);
        check("mrst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check("mrst_stream_error", 32'(stream_error), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_release_ready", 32'(din_ready), 32'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 24'h00000F); step();
        drive(1'b1, 1'b0, 1'b0, 24'h080700); step();
        drive(1'b1, 1'b0, 1'b0, 24'h040000); step();
        drive(1'b1, 1'b0, 1'b1, 24'h000803); step();
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        check("mrst_ctrl_valid_after", 32'(ctrl_valid), 32'd1);
        check("mrst_width_after", 32'(width), 32'd1920);
        check("mrst_height_after", 32'(height), 32'd1080);
        check("mrst_error_after", 32'(stream_error), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
